sram_bus_arbiter: RTL and testbench

- Shares the external SRAM bus (address MAH/MAL, MD, M1CSn/MRDn/MWRn) between two requesters: the CPU bus decoder and the ICD/debug DMA port.
- Arbitrates each access, then sequences the SRAM strobes with fixed setup/strobe/hold timing. Returns read data and a one-cycle ack to the granted requester.
- Sits in NORA between the address decoder / ICD SPI slave and the top-level memory pins.

---
 rtl/sram_bus_arbiter_pkg.sv | 21 ++
 rtl/sram_bus_arbiter_cycle_seq.sv | 132 +++++++++++++
 rtl/sram_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for the SRAM bus arbiter: sequencer state encoding,
// default SRAM address width and requester identifiers.
package sram_bus_arbiter_pkg;

  localparam int SRAM_AW = 21;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_ICD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } seq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_bus_arbiter_cycle_seq.sv
// Single-port SRAM timing engine: latches one access on start and drives
// registered SETUP / STROBE / HOLD pin timing.
module sram_cycle_seq
  import sram_bus_arbiter_pkg::*;
#(
  parameter int AW     = SRAM_AW,
  parameter int RD_CYC = 2,
  parameter int WR_CYC = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          rwn,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_wdata_oe,
  output logic          m1csn,
  output logic          mrdn,
  output logic          mwrn,
  output logic          busy,
  output logic          last_strobe,
  output logic          rd_capture
);

  localparam int CW = $clog2(max_int(RD_CYC, WR_CYC)) + 1;

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rwn_q, rwn_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          oe_q, oe_d;
  logic          csn_q, csn_d;
  logic          rdn_q, rdn_d;
  logic          wrn_q, wrn_d;
  logic          busy_q, busy_d;

  // Next-state and next-pin computation; every pin value is registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rwn_d   = rwn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    oe_d    = oe_q;
    csn_d   = csn_q;
    rdn_d   = rdn_q;
    wrn_d   = wrn_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          rwn_d   = rwn;
          addr_d  = addr;
          wdata_d = wdata;
          oe_d    = ~rwn;
          csn_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = rwn_q ? CW'(RD_CYC) : CW'(WR_CYC);
        rdn_d   = ~rwn_q;
        wrn_d   = rwn_q;
      end
      ST_STROBE: begin
        if (cnt_q == CW'(1)) begin
          state_d = ST_HOLD;
          rdn_d   = 1'b1;
          wrn_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        csn_d   = 1'b1;
        oe_d    = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        oe_d    = 1'b0;
        csn_d   = 1'b1;
        rdn_d   = 1'b1;
        wrn_d   = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and pin registers; reset forces all strobes inactive at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      rwn_q   <= 1'b1;
      addr_q  <= {AW{1'b0}};
      wdata_q <= 8'h00;
      oe_q    <= 1'b0;
      csn_q   <= 1'b1;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rwn_q   <= rwn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      oe_q    <= oe_d;
      csn_q   <= csn_d;
      rdn_q   <= rdn_d;
      wrn_q   <= wrn_d;
      busy_q  <= busy_d;
    end
  end

  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wdata_oe = oe_q;
  assign m1csn        = csn_q;
  assign mrdn         = rdn_q;
  assign mwrn         = wrn_q;
  assign busy         = busy_q;
  assign last_strobe  = (state_q == ST_STROBE) && (cnt_q == CW'(1));
  assign rd_capture   = last_strobe & rwn_q;

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates the CPU and ICD ports onto one external SRAM bus, with bounded
// deferral of ICD, and steers the one-cycle ack and read data back.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int AW            = SRAM_AW,
  parameter int RD_CYC        = 2,
  parameter int WR_CYC        = 2,
  parameter int ICD_MAX_DEFER = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cpu_req,
  input  logic          cpu_rwn,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ack,
  output logic [7:0]    cpu_rdata,
  input  logic          icd_req,
  input  logic          icd_rwn,
  input  logic [AW-1:0] icd_addr,
  input  logic [7:0]    icd_wdata,
  output logic          icd_ack,
  output logic [7:0]    icd_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_wdata_oe,
  input  logic [7:0]    mem_rdata,
  output logic          m1csn,
  output logic          mrdn,
  output logic          mwrn,
  output logic          busy
);

  localparam int DW = (ICD_MAX_DEFER > 0) ? $clog2(ICD_MAX_DEFER + 1) : 1;

  logic          icd_wins_s, start_s, last_s, cap_s;
  logic          seq_rwn_s;
  logic [AW-1:0] seq_addr_s;
  logic [7:0]    seq_wdata_s;
  logic [DW-1:0] defer_q, defer_d;
  logic          grant_q, grant_d;
  logic          cpu_ack_q, cpu_ack_d, icd_ack_q, icd_ack_d;
  logic [7:0]    cpu_rdata_q, cpu_rdata_d, icd_rdata_q, icd_rdata_d;

  // Grant decision in IDLE, deferral bookkeeping and per-port return steering.
  always_comb begin
    if (cpu_req && icd_req) begin
      icd_wins_s = (ICD_MAX_DEFER != 0) && (defer_q == DW'(ICD_MAX_DEFER));
    end else begin
      icd_wins_s = icd_req;
    end
    start_s     = ~busy & (cpu_req | icd_req);
    seq_rwn_s   = icd_wins_s ? icd_rwn   : cpu_rwn;
    seq_addr_s  = icd_wins_s ? icd_addr  : cpu_addr;
    seq_wdata_s = icd_wins_s ? icd_wdata : cpu_wdata;

    if (busy) begin
      defer_d = defer_q;
    end else if (!icd_req || icd_wins_s) begin
      defer_d = {DW{1'b0}};
    end else if (cpu_req && (defer_q != DW'(ICD_MAX_DEFER))) begin
      defer_d = defer_q + DW'(1);
    end else begin
      defer_d = defer_q;
    end

    if (start_s) begin
      grant_d = icd_wins_s ? REQ_ICD : REQ_CPU;
    end else begin
      grant_d = grant_q;
    end

    // last_s is the final STROBE cycle, so these acks land in HOLD.
    cpu_ack_d = last_s && (grant_q == REQ_CPU);
    icd_ack_d = last_s && (grant_q == REQ_ICD);

    if (cap_s && (grant_q == REQ_CPU)) begin
      cpu_rdata_d = mem_rdata;
    end else begin
      cpu_rdata_d = cpu_rdata_q;
    end
    if (cap_s && (grant_q == REQ_ICD)) begin
      icd_rdata_d = mem_rdata;
    end else begin
      icd_rdata_d = icd_rdata_q;
    end
  end

  // Arbiter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      defer_q     <= {DW{1'b0}};
      grant_q     <= REQ_CPU;
      cpu_ack_q   <= 1'b0;
      icd_ack_q   <= 1'b0;
      cpu_rdata_q <= 8'h00;
      icd_rdata_q <= 8'h00;
    end else begin
      defer_q     <= defer_d;
      grant_q     <= grant_d;
      cpu_ack_q   <= cpu_ack_d;
      icd_ack_q   <= icd_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      icd_rdata_q <= icd_rdata_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign icd_ack   = icd_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign icd_rdata = icd_rdata_q;

  sram_cycle_seq #(
    .AW     (AW),
    .RD_CYC (RD_CYC),
    .WR_CYC (WR_CYC)
  ) u_seq (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start_s),
    .rwn          (seq_rwn_s),
    .addr         (seq_addr_s),
    .wdata        (seq_wdata_s),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wdata_oe (mem_wdata_oe),
    .m1csn        (m1csn),
    .mrdn         (mrdn),
    .mwrn         (mwrn),
    .busy         (busy),
    .last_strobe  (last_s),
    .rd_capture   (cap_s)
  );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench: instance A (RD=2, WR=2, defer 4) and instance B (RD=3, defer 0),
// each with a small SRAM model; read of a never-written byte returns addr[7:0]^0xA5.
module tb_sram_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  int checks = 0;
  int passes = 0;

  logic        a_cpu_req, a_cpu_rwn, a_cpu_ack, a_icd_req, a_icd_rwn, a_icd_ack;
  logic [20:0] a_cpu_addr, a_icd_addr, a_mem_addr;
  logic [7:0]  a_cpu_wdata, a_cpu_rdata, a_icd_wdata, a_icd_rdata, a_mem_wdata, a_mem_rdata;
  logic        a_mem_wdata_oe, a_m1csn, a_mrdn, a_mwrn, a_busy;

  logic        b_cpu_req, b_cpu_rwn, b_cpu_ack, b_icd_req, b_icd_rwn, b_icd_ack;
  logic [20:0] b_cpu_addr, b_icd_addr, b_mem_addr;
  logic [7:0]  b_cpu_wdata, b_cpu_rdata, b_icd_wdata, b_icd_rdata, b_mem_wdata, b_mem_rdata;
  logic        b_mem_wdata_oe, b_m1csn, b_mrdn, b_mwrn, b_busy;

  bit [7:0] mem_a [256];
  bit       wr_a  [256];

  always @(posedge clk) begin
    if (!a_m1csn && !a_mwrn) begin
      mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
      wr_a[a_mem_addr[7:0]]  <= 1'b1;
    end
  end
  assign a_mem_rdata = wr_a[a_mem_addr[7:0]] ? mem_a[a_mem_addr[7:0]] : (a_mem_addr[7:0] ^ 8'hA5);
  assign b_mem_rdata = b_mem_addr[7:0] ^ 8'hA5;

  sram_bus_arbiter #(.AW(21), .RD_CYC(2), .WR_CYC(2), .ICD_MAX_DEFER(4)) u_dut_a (
    .clk(clk), .resetn(resetn),
    .cpu_req(a_cpu_req), .cpu_rwn(a_cpu_rwn), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
    .icd_req(a_icd_req), .icd_rwn(a_icd_rwn), .icd_addr(a_icd_addr), .icd_wdata(a_icd_wdata),
    .icd_ack(a_icd_ack), .icd_rdata(a_icd_rdata),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wdata_oe(a_mem_wdata_oe),
    .mem_rdata(a_mem_rdata), .m1csn(a_m1csn), .mrdn(a_mrdn), .mwrn(a_mwrn), .busy(a_busy)
  );

  sram_bus_arbiter #(.AW(21), .RD_CYC(3), .WR_CYC(2), .ICD_MAX_DEFER(0)) u_dut_b (
    .clk(clk), .resetn(resetn),
    .cpu_req(b_cpu_req), .cpu_rwn(b_cpu_rwn), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .icd_req(b_icd_req), .icd_rwn(b_icd_rwn), .icd_addr(b_icd_addr), .icd_wdata(b_icd_wdata),
    .icd_ack(b_icd_ack), .icd_rdata(b_icd_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wdata_oe(b_mem_wdata_oe),
    .mem_rdata(b_mem_rdata), .m1csn(b_m1csn), .mrdn(b_mrdn), .mwrn(b_mwrn), .busy(b_busy)
  );

  task automatic test_reset();
    resetn = 1'b0;
    a_cpu_req = 1'b0; a_cpu_rwn = 1'b1; a_cpu_addr = 21'h0; a_cpu_wdata = 8'h00;
    a_icd_req = 1'b0; a_icd_rwn = 1'b1; a_icd_addr = 21'h0; a_icd_wdata = 8'h00;
    b_cpu_req = 1'b0; b_cpu_rwn = 1'b1; b_cpu_addr = 21'h0; b_cpu_wdata = 8'h00;
    b_icd_req = 1'b0; b_icd_rwn = 1'b1; b_icd_addr = 21'h0; b_icd_wdata = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_m1csn, a_mrdn, a_mwrn} !== 3'b111) $display("FAIL reset_strobes: got %b expected 111", {a_m1csn, a_mrdn, a_mwrn});
    else passes++;
    checks++;
    if ({a_mem_wdata_oe, a_busy, a_cpu_ack, a_icd_ack} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b expected 0000", {a_mem_wdata_oe, a_busy, a_cpu_ack, a_icd_ack});
    else passes++;
    checks++;
    if ({a_mem_addr, a_mem_wdata, a_cpu_rdata, a_icd_rdata} !== 45'h0)
      $display("FAIL reset_data: got addr %h wdata %h crd %h ird %h expected all 0", a_mem_addr, a_mem_wdata, a_cpu_rdata, a_icd_rdata);
    else passes++;
    checks++;
    if ({b_m1csn, b_busy} !== 2'b10) $display("FAIL reset_b: got %b expected 10", {b_m1csn, b_busy});
    else passes++;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int ack_k, acks, low, setup_oe, hold_oe, hold_wr, idle_oe;
    logic [7:0] hold_wd;
    ack_k = -1; acks = 0; low = 0; setup_oe = 0; hold_oe = 0; hold_wr = 0; idle_oe = 1; hold_wd = 8'h00;
    @(negedge clk);
    a_cpu_req = 1'b1; a_cpu_rwn = 1'b0; a_cpu_addr = 21'h000010; a_cpu_wdata = 8'h12;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!a_mwrn) low++;
      if (a_cpu_ack) begin acks++; if (ack_k < 0) ack_k = k; a_cpu_req = 1'b0; end
      if (k == 1) setup_oe = int'(a_mem_wdata_oe);
      if (k == 4) begin hold_oe = int'(a_mem_wdata_oe); hold_wr = int'(a_mwrn); hold_wd = a_mem_wdata; end
      if (k == 5) idle_oe = int'(a_mem_wdata_oe);
    end
    checks++; if (ack_k != 4) $display("FAIL wr_ack_latency: got %0d expected 4", ack_k); else passes++;
    checks++; if (acks != 1) $display("FAIL wr_ack_count: got %0d expected 1", acks); else passes++;
    checks++; if (low != 2) $display("FAIL wr_mwrn_width: got %0d expected 2", low); else passes++;
    checks++; if (setup_oe != 1) $display("FAIL wr_setup_oe: got %0d expected 1", setup_oe); else passes++;
    checks++;
    if (hold_oe != 1 || hold_wr != 1 || hold_wd !== 8'h12)
      $display("FAIL wr_data_hold: got oe %0d mwrn %0d data %h expected oe 1 mwrn 1 data 12", hold_oe, hold_wr, hold_wd);
    else passes++;
    checks++; if (idle_oe != 0) $display("FAIL wr_idle_oe: got %0d expected 0", idle_oe); else passes++;
    checks++;
    if (!wr_a[8'h10] || mem_a[8'h10] !== 8'h12) $display("FAIL wr_mem: got %h expected 12", mem_a[8'h10]);
    else passes++;

    ack_k = -1; low = 0;
    @(negedge clk);
    a_cpu_req = 1'b1; a_cpu_rwn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!a_mrdn) low++;
      if (a_cpu_ack && ack_k < 0) begin ack_k = k; a_cpu_req = 1'b0; end
    end
    checks++; if (ack_k != 4) $display("FAIL rd_ack_latency: got %0d expected 4", ack_k); else passes++;
    checks++; if (low != 2) $display("FAIL rd_mrdn_width: got %0d expected 2", low); else passes++;
    checks++; if (a_cpu_rdata !== 8'h12) $display("FAIL rd_data: got %h expected 12", a_cpu_rdata); else passes++;
  endtask

  task automatic test_icd_read_rd3();
    int ack_k, acks, cpu_acks, low;
    ack_k = -1; acks = 0; cpu_acks = 0; low = 0;
    @(negedge clk);
    b_icd_req = 1'b1; b_icd_rwn = 1'b1; b_icd_addr = 21'h000020;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (!b_mrdn) low++;
      if (b_cpu_ack) cpu_acks++;
      if (b_icd_ack) begin acks++; if (ack_k < 0) ack_k = k; b_icd_req = 1'b0; end
    end
    checks++; if (ack_k != 5) $display("FAIL icd_ack_latency: got %0d expected 5", ack_k); else passes++;
    checks++; if (acks != 1) $display("FAIL icd_ack_count: got %0d expected 1", acks); else passes++;
    checks++; if (low != 3) $display("FAIL icd_mrdn_width: got %0d expected 3", low); else passes++;
    checks++; if (cpu_acks != 0) $display("FAIL icd_no_cpu_ack: got %0d expected 0", cpu_acks); else passes++;
    checks++; if (b_icd_rdata !== 8'h85) $display("FAIL icd_rdata: got %h expected 85", b_icd_rdata); else passes++;
    checks++; if (b_cpu_rdata !== 8'h00) $display("FAIL icd_cpu_rdata_kept: got %h expected 00", b_cpu_rdata); else passes++;
  endtask

  task automatic test_tie();
    int cpu_k, icd_k, cpu_n, icd_n;
    cpu_k = -1; icd_k = -1; cpu_n = 0; icd_n = 0;
    @(negedge clk);
    a_cpu_req = 1'b1; a_cpu_rwn = 1'b1; a_cpu_addr = 21'h000010;
    a_icd_req = 1'b1; a_icd_rwn = 1'b1; a_icd_addr = 21'h000030;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (a_cpu_ack) begin cpu_n++; if (cpu_k < 0) cpu_k = k; a_cpu_req = 1'b0; end
      if (a_icd_ack) begin icd_n++; if (icd_k < 0) icd_k = k; a_icd_req = 1'b0; end
    end
    checks++; if (cpu_k != 4) $display("FAIL tie_cpu_first: got %0d expected 4", cpu_k); else passes++;
    checks++; if (icd_k != 9) $display("FAIL tie_icd_next: got %0d expected 9", icd_k); else passes++;
    checks++;
    if (cpu_n != 1 || icd_n != 1) $display("FAIL tie_ack_counts: got cpu %0d icd %0d expected 1 1", cpu_n, icd_n);
    else passes++;
    checks++; if (a_icd_rdata !== 8'h95) $display("FAIL tie_icd_rdata: got %h expected 95", a_icd_rdata); else passes++;
    checks++; if (a_cpu_rdata !== 8'h12) $display("FAIL tie_cpu_rdata: got %h expected 12", a_cpu_rdata); else passes++;
  endtask

  task automatic test_defer_limit();
    int ord [6];
    int exp_ord [6];
    int n, icd_k;
    exp_ord = '{0, 0, 0, 0, 1, 0};
    n = 0; icd_k = -1;
    for (int i = 0; i < 6; i++) ord[i] = -1;
    @(negedge clk);
    a_cpu_req = 1'b1; a_cpu_rwn = 1'b1; a_cpu_addr = 21'h000010;
    a_icd_req = 1'b1; a_icd_rwn = 1'b1; a_icd_addr = 21'h000030;
    for (int k = 1; k <= 40 && n < 6; k++) begin
      @(negedge clk);
      if (a_cpu_ack && n < 6) begin ord[n] = 0; n++; end
      if (a_icd_ack && n < 6) begin ord[n] = 1; n++; icd_k = k; a_icd_req = 1'b0; end
    end
    a_cpu_req = 1'b0; a_icd_req = 1'b0;
    checks++; if (n != 6) $display("FAIL defer_ack_total: got %0d expected 6", n); else passes++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ord[i] != exp_ord[i]) $display("FAIL defer_order[%0d]: got %0d expected %0d", i, ord[i], exp_ord[i]);
      else passes++;
    end
    checks++; if (icd_k != 24) $display("FAIL defer_icd_cycle: got %0d expected 24", icd_k); else passes++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_defer_zero();
    int ord [4];
    int exp_ord [4];
    int n, cpu_n, icd_k;
    exp_ord = '{0, 0, 0, 1};
    n = 0; cpu_n = 0; icd_k = -1;
    for (int i = 0; i < 4; i++) ord[i] = -1;
    @(negedge clk);
    b_cpu_req = 1'b1; b_cpu_rwn = 1'b1; b_cpu_addr = 21'h000011;
    b_icd_req = 1'b1; b_icd_rwn = 1'b1; b_icd_addr = 21'h000031;
    for (int k = 1; k <= 40 && n < 4; k++) begin
      @(negedge clk);
      if (b_cpu_ack && n < 4) begin ord[n] = 0; n++; cpu_n++; if (cpu_n == 3) b_cpu_req = 1'b0; end
      if (b_icd_ack && n < 4) begin ord[n] = 1; n++; icd_k = k; b_icd_req = 1'b0; end
    end
    b_cpu_req = 1'b0; b_icd_req = 1'b0;
    checks++; if (n != 4) $display("FAIL defer0_ack_total: got %0d expected 4", n); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ord[i] != exp_ord[i]) $display("FAIL defer0_order[%0d]: got %0d expected %0d", i, ord[i], exp_ord[i]);
      else passes++;
    end
    checks++; if (icd_k != 23) $display("FAIL defer0_icd_cycle: got %0d expected 23", icd_k); else passes++;
    checks++; if (b_icd_rdata !== 8'h94) $display("FAIL defer0_icd_rdata: got %h expected 94", b_icd_rdata); else passes++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_top_addr();
    int ack_k;
    ack_k = -1;
    @(negedge clk);
    a_cpu_req = 1'b1; a_cpu_rwn = 1'b1; a_cpu_addr = 21'h1FFFFF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (a_cpu_ack && ack_k < 0) begin ack_k = k; a_cpu_req = 1'b0; end
      if (k <= 4) begin
        checks++;
        if (a_mem_addr !== 21'h1FFFFF) $display("FAIL top_addr_k%0d: got %h expected 1fffff", k, a_mem_addr);
        else passes++;
      end
    end
    checks++; if (ack_k != 4) $display("FAIL top_ack_latency: got %0d expected 4", ack_k); else passes++;
    checks++; if (a_cpu_rdata !== 8'h5A) $display("FAIL top_rdata: got %h expected 5a", a_cpu_rdata); else passes++;
  endtask

  task automatic test_reset_mid_write();
    int acks, ack_k;
    acks = 0; ack_k = -1;
    @(negedge clk);
    a_cpu_req = 1'b1; a_cpu_rwn = 1'b0; a_cpu_addr = 21'h000040; a_cpu_wdata = 8'h99;
    repeat (2) @(negedge clk);
    checks++; if (a_mwrn !== 1'b0) $display("FAIL rst_in_strobe: got mwrn %b expected 0", a_mwrn); else passes++;
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({a_m1csn, a_mwrn, a_mrdn, a_mem_wdata_oe, a_busy} !== 5'b11100)
      $display("FAIL rst_async_pins: got %b expected 11100", {a_m1csn, a_mwrn, a_mrdn, a_mem_wdata_oe, a_busy});
    else passes++;
    checks++; if (a_cpu_rdata !== 8'h00) $display("FAIL rst_rdata_clear: got %h expected 00", a_cpu_rdata); else passes++;
    a_cpu_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (a_cpu_ack) acks++;
      if (k == 1) resetn = 1'b1;
    end
    checks++; if (acks != 0) $display("FAIL rst_no_ack: got %0d expected 0", acks); else passes++;

    a_cpu_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (a_cpu_ack && ack_k < 0) begin ack_k = k; a_cpu_req = 1'b0; end
    end
    checks++; if (ack_k != 4) $display("FAIL rst_recover_ack: got %0d expected 4", ack_k); else passes++;
    checks++;
    if (!wr_a[8'h40] || mem_a[8'h40] !== 8'h99) $display("FAIL rst_recover_mem: got %h expected 99", mem_a[8'h40]);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_icd_read_rd3();
    test_tie();
    test_defer_limit();
    test_defer_zero();
    test_top_addr();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
